// File: rtl/tlm_fifo.sv
// Synchronous FIFO channel between a put_export producer and a get_export consumer.
// Registered storage with a one-cycle put-to-get latency and no combinational bypass.
module tlm_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       put_valid,
  output logic                       put_ready,
  input  logic [WIDTH-1:0]           put_data,
  output logic                       get_valid,
  input  logic                       get_ready,
  output logic [WIDTH-1:0]           get_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             put_fire;
  logic             get_fire;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_comb begin
    full      = (count_q == CntW'(DEPTH));
    empty     = (count_q == '0);
    put_ready = !full;
    get_valid = !empty;
    get_data  = mem_q[rd_ptr_q];
    count     = count_q;
    put_fire  = put_valid && put_ready;
    get_fire  = get_valid && get_ready;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (put_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (get_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (put_fire && !get_fire) begin
      count_d = count_q + 1'b1;
    end else if (get_fire && !put_fire) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; reset only discards it via the pointers.
  always_ff @(posedge clk) begin
    if (!rst && put_fire) begin
      mem_q[wr_ptr_q] <= put_data;
    end
  end

endmodule

// File: tb/tb_tlm_fifo.sv
// Directed self-checking bench for tlm_fifo at DEPTH=3, WIDTH=32.
// Inputs change 1ns after a rising edge; outputs are sampled in that same quiet window.
module tb_tlm_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 3;

  logic             clk;
  logic             rst;
  logic             put_valid;
  logic             put_ready;
  logic [WIDTH-1:0] put_data;
  logic             get_valid;
  logic             get_ready;
  logic [WIDTH-1:0] get_data;
  logic [1:0]       count;
  logic             full;
  logic             empty;

  int checks;
  int failures;

  tlm_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .put_valid(put_valid),
    .put_ready(put_ready),
    .put_data (put_data),
    .get_valid(get_valid),
    .get_ready(get_ready),
    .get_data (get_data),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    put_valid = 1'b0;
    get_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    put_data = '0;
    step();
    step();
    rst = 1'b0;
    step();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (get_valid !== 1'b0) begin failures++; $display("FAIL reset_get_valid got %b want 0", get_valid); end
    checks++; if (put_ready !== 1'b1) begin failures++; $display("FAIL reset_put_ready got %b want 1", put_ready); end
  endtask

  task automatic test_fill_drain();
    logic [31:0] words [4];
    words[0] = 32'hA1; words[1] = 32'hA2; words[2] = 32'hA3; words[3] = 32'hA4;
    for (int i = 0; i < 3; i++) begin
      put_valid = 1'b1;
      put_data  = words[i];
      get_ready = 1'b0;
      step();
      checks++; if (count !== 2'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
      checks++; if (get_data !== 32'hA1) begin failures++; $display("FAIL fill_head[%0d] got %h want a1", i, get_data); end
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got %b want 1", full); end
    checks++; if (put_ready !== 1'b0) begin failures++; $display("FAIL fill_put_ready got %b want 0", put_ready); end
    put_data = words[3];
    step();
    checks++; if (count !== 2'd3) begin failures++; $display("FAIL put_when_full_count got %0d want 3", count); end
    idle();
    get_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (get_data !== words[i]) begin failures++; $display("FAIL drain_data[%0d] got %h want %h", i, get_data, words[i]); end
      step();
    end
    idle();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got %b want 1", empty); end
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL drain_count got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    for (int v = 1; v <= 10; v++) begin
      put_valid = 1'b1;
      put_data  = 32'(v);
      get_ready = 1'b0;
      step();
      put_valid = 1'b0;
      get_ready = 1'b1;
      checks++; if (get_valid !== 1'b1 || get_data !== 32'(v)) begin
        failures++; $display("FAIL wrap_data[%0d] got v=%b d=%h want v=1 d=%h", v, get_valid, get_data, 32'(v));
      end
      step();
    end
    idle();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got %b want 1", empty); end
  endtask

  task automatic test_full_put_get();
    logic [31:0] exp [3];
    exp[0] = 32'h12; exp[1] = 32'h13; exp[2] = 32'h14;
    for (int i = 0; i < 3; i++) begin
      put_valid = 1'b1;
      put_data  = 32'h11 + 32'(i);
      step();
    end
    put_data  = 32'h14;
    get_ready = 1'b1;
    checks++; if (put_ready !== 1'b0) begin failures++; $display("FAIL fullpg_put_ready got %b want 0", put_ready); end
    checks++; if (get_data !== 32'h11) begin failures++; $display("FAIL fullpg_head got %h want 11", get_data); end
    step();
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL fullpg_count got %0d want 2", count); end
    checks++; if (put_ready !== 1'b1) begin failures++; $display("FAIL fullpg_reoffer got %b want 1", put_ready); end
    get_ready = 1'b0;
    step();
    checks++; if (count !== 2'd3) begin failures++; $display("FAIL fullpg_accept_count got %0d want 3", count); end
    idle();
    get_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (get_data !== exp[i]) begin failures++; $display("FAIL fullpg_drain[%0d] got %h want %h", i, get_data, exp[i]); end
      step();
    end
    idle();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fullpg_empty got %b want 1", empty); end
  endtask

  task automatic test_back_to_back();
    put_valid = 1'b1;
    put_data  = 32'd100;
    step();
    for (int i = 0; i < 20; i++) begin
      put_valid = 1'b1;
      put_data  = 32'd101 + 32'(i);
      get_ready = 1'b1;
      checks++; if (get_data !== 32'd100 + 32'(i) || count !== 2'd1) begin
        failures++; $display("FAIL steady[%0d] got d=%0d c=%0d want d=%0d c=1", i, get_data, count, 100 + i);
      end
      step();
    end
    idle();
    checks++; if (count !== 2'd1 || get_data !== 32'd120) begin
      failures++; $display("FAIL steady_end got d=%0d c=%0d want d=120 c=1", get_data, count);
    end
    get_ready = 1'b1;
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    put_valid = 1'b1;
    put_data  = 32'h51;
    step();
    put_data  = 32'h52;
    step();
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL rstmid_pre_count got %0d want 2", count); end
    rst       = 1'b1;
    put_data  = 32'h53;
    get_ready = 1'b1;
    step();
    rst = 1'b0;
    idle();
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL rstmid_count got %0d want 0", count); end
    checks++; if (get_valid !== 1'b0) begin failures++; $display("FAIL rstmid_get_valid got %b want 0", get_valid); end
    step();
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rstmid_still_empty got %b want 1", empty); end
    put_valid = 1'b1;
    put_data  = 32'h60;
    step();
    idle();
    checks++; if (get_data !== 32'h60 || count !== 2'd1) begin
      failures++; $display("FAIL rstmid_after got d=%h c=%0d want d=60 c=1", get_data, count);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_put_get();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
